// File: rtl/fft8_pkg.sv
// Shared constants and helpers for the 8-point streaming DFT.
//   SAMPLE_W : width of one real input sample
//   BIN_W    : width of the real and imaginary parts of every intermediate and output bin
//   NPOINT   : transform length
//   TW_C     : cos(pi/4) in Q15, used for the odd twiddles W8^1 and W8^3
//   TW_SHIFT : right shift that rescales a Q15 twiddle product
package fft8_pkg;

   localparam int SAMPLE_W = 8;
   localparam int BIN_W    = 32;
   localparam int NPOINT   = 8;
   localparam int TW_C     = 23170;
   localparam int TW_SHIFT = 15;

   // re occupies the upper half, so a packed cplx_t drops straight into the output bus
   typedef struct packed {
      logic signed [BIN_W-1:0] re;
      logic signed [BIN_W-1:0] im;
   } cplx_t;

   // v * W8^k. W8^0 and W8^2 (= -j) need no multiplier. W8^1 and W8^3 use Q15
   // constants with one arithmetic shift per sum, so results round toward -inf.
   function automatic cplx_t twiddle8(input cplx_t v, input logic [1:0] k);
      cplx_t                     r;
      logic signed [2*BIN_W-1:0] re_w, im_w, cr, ci, pre, pim;
      r    = v;
      re_w = v.re;
      im_w = v.im;
      cr   = '0;
      ci   = '0;
      pre  = '0;
      pim  = '0;
      case (k)
         2'd0: r = v;
         2'd2: begin
            r.re = v.im;
            r.im = -v.re;
         end
         default: begin
            // W8^1 = c*(1-j), W8^3 = c*(-1-j)
            cr   = (k == 2'd1) ? 64'(TW_C) : -64'(TW_C);
            ci   = -64'(TW_C);
            pre  = (re_w * cr - im_w * ci) >>> TW_SHIFT;
            pim  = (re_w * ci + im_w * cr) >>> TW_SHIFT;
            r.re = pre[BIN_W-1:0];
            r.im = pim[BIN_W-1:0];
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/fft8_butterfly.sv
// Combinational radix-2 complex butterfly: sum = a + b, dif = a - b.
//   a_re/a_im, b_re/b_im     : operands
//   sum_re/sum_im            : a + b
//   dif_re/dif_im            : a - b (the caller applies any twiddle)
module fft8_butterfly
   import fft8_pkg::*;
(
   input  logic signed [BIN_W-1:0] a_re,
   input  logic signed [BIN_W-1:0] a_im,
   input  logic signed [BIN_W-1:0] b_re,
   input  logic signed [BIN_W-1:0] b_im,
   output logic signed [BIN_W-1:0] sum_re,
   output logic signed [BIN_W-1:0] sum_im,
   output logic signed [BIN_W-1:0] dif_re,
   output logic signed [BIN_W-1:0] dif_im
);

   assign sum_re = a_re + b_re;
   assign sum_im = a_im + b_im;
   assign dif_re = a_re - b_re;
   assign dif_im = a_im - b_im;

endmodule

// File: rtl/axis_fft_8point_dft.sv
// AXI-Stream 8-point forward DFT (radix-2 DIF, no 1/N scaling).
// One beat carries eight signed 8-bit real samples in and eight complex
// 32+32-bit bins out, in natural order.
//   s_axis_aclk / s_axis_areset : clock, synchronous active-high reset
//   s_axis_*                    : input stream, x[n] at tdata[8n+7:8n]
//   m_axis_*                    : output stream, X[k] re at [64k+63:64k+32],
//                                 im at [64k+31:64k]; tkeep/tstrb all ones
// Pipeline: input reg -> stage 1 -> stage 2 -> stage 3/output reg. The whole
// pipe moves as one when the output slot is empty or being taken, so bubbles
// stay in place during a stall and tready is a pure function of the output slot.
module axis_fft_8point_dft
   import fft8_pkg::*;
#(
   parameter int C_AXIS_TDATA_WIDTH = 64,
   parameter int C_AXIS_TOUT_WIDTH  = 512,
   parameter int C_AXIS_TUSER_WIDTH = 1
)(
   input  logic                            s_axis_aclk,
   input  logic                            s_axis_areset,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                            s_axis_tlast,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [C_AXIS_TOUT_WIDTH-1:0]    m_axis_tdata,
   output logic [C_AXIS_TOUT_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_AXIS_TOUT_WIDTH/8-1:0]  m_axis_tstrb,
   output logic                            m_axis_tlast,
   output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser
);

   localparam int STAGES = 4;
   localparam int HALF   = NPOINT / 2;

   logic                          en;
   logic [STAGES-1:0]             vld_pipe;
   logic [STAGES-1:0]             last_pipe;
   logic [C_AXIS_TUSER_WIDTH-1:0] user_pipe [STAGES];

   logic signed [BIN_W-1:0] x_q [NPOINT];
   cplx_t s1_d [NPOINT];
   cplx_t s1_q [NPOINT];
   cplx_t s2_d [NPOINT];
   cplx_t s2_q [NPOINT];
   cplx_t s3_d [NPOINT];
   cplx_t s3_q [NPOINT];

   assign en            = ~vld_pipe[STAGES-1] | m_axis_tready;
   assign s_axis_tready = en;

   // Stage 1: s1[k] = a_k = x_k + x_(k+4); s1[k+4] = b_k = (x_k - x_(k+4)) * W8^k
   for (genvar g = 0; g < HALF; g++) begin : g_s1
      logic signed [BIN_W-1:0] sum_re, sum_im, dif_re, dif_im;
      fft8_butterfly u_bf (
         .a_re   (x_q[g]),
         .a_im   ({BIN_W{1'b0}}),
         .b_re   (x_q[g+HALF]),
         .b_im   ({BIN_W{1'b0}}),
         .sum_re (sum_re),
         .sum_im (sum_im),
         .dif_re (dif_re),
         .dif_im (dif_im)
      );
      assign s1_d[g]      = cplx_t'{sum_re, sum_im};
      assign s1_d[g+HALF] = twiddle8(cplx_t'{dif_re, dif_im}, 2'(g));
   end

   // Stage 2: length-4 DIF on each half (a at base 0, b at base 4).
   // Within a half: [0..1] = sums, [2..3] = differences times W4^k (W8^0, W8^2).
   for (genvar g = 0; g < HALF; g++) begin : g_s2
      localparam int BA = 4 * (g / 2);
      localparam int K  = g % 2;
      logic signed [BIN_W-1:0] sum_re, sum_im, dif_re, dif_im;
      fft8_butterfly u_bf (
         .a_re   (s1_q[BA+K].re),
         .a_im   (s1_q[BA+K].im),
         .b_re   (s1_q[BA+K+2].re),
         .b_im   (s1_q[BA+K+2].im),
         .sum_re (sum_re),
         .sum_im (sum_im),
         .dif_re (dif_re),
         .dif_im (dif_im)
      );
      assign s2_d[BA+K]   = cplx_t'{sum_re, sum_im};
      assign s2_d[BA+2+K] = twiddle8(cplx_t'{dif_re, dif_im}, 2'(2*K));
   end

   // Stage 3: length-2 butterflies on adjacent pairs. Pair g holds bins
   // bitrev2(g) and bitrev2(g)+4, so writing them there yields natural order.
   for (genvar g = 0; g < HALF; g++) begin : g_s3
      localparam int BR = (g % 2) * 2 + (g / 2);
      logic signed [BIN_W-1:0] sum_re, sum_im, dif_re, dif_im;
      fft8_butterfly u_bf (
         .a_re   (s2_q[2*g].re),
         .a_im   (s2_q[2*g].im),
         .b_re   (s2_q[2*g+1].re),
         .b_im   (s2_q[2*g+1].im),
         .sum_re (sum_re),
         .sum_im (sum_im),
         .dif_re (dif_re),
         .dif_im (dif_im)
      );
      assign s3_d[BR]      = cplx_t'{sum_re, sum_im};
      assign s3_d[BR+HALF] = cplx_t'{dif_re, dif_im};
   end

   always_ff @(posedge s_axis_aclk) begin
      if (s_axis_areset) begin
         vld_pipe  <= '0;
         last_pipe <= '0;
         for (int i = 0; i < STAGES; i++) user_pipe[i] <= '0;
         for (int n = 0; n < NPOINT; n++) begin
            x_q[n]  <= '0;
            s1_q[n] <= '0;
            s2_q[n] <= '0;
            s3_q[n] <= '0;
         end
      end else if (en) begin
         vld_pipe     <= {vld_pipe[STAGES-2:0], s_axis_tvalid};
         last_pipe    <= {last_pipe[STAGES-2:0], s_axis_tlast};
         user_pipe[0] <= s_axis_tuser;
         for (int i = 1; i < STAGES; i++) user_pipe[i] <= user_pipe[i-1];
         for (int n = 0; n < NPOINT; n++) begin
            x_q[n]  <= BIN_W'($signed(s_axis_tdata[SAMPLE_W*n +: SAMPLE_W]));
            s1_q[n] <= s1_d[n];
            s2_q[n] <= s2_d[n];
            s3_q[n] <= s3_d[n];
         end
      end
   end

   for (genvar k = 0; k < NPOINT; k++) begin : g_out
      assign m_axis_tdata[2*BIN_W*k +: 2*BIN_W] = s3_q[k];
   end

   assign m_axis_tvalid = vld_pipe[STAGES-1];
   assign m_axis_tlast  = last_pipe[STAGES-1];
   assign m_axis_tuser  = user_pipe[STAGES-1];
   assign m_axis_tkeep  = '1;
   assign m_axis_tstrb  = '1;

endmodule

// File: tb/tb_axis_fft_8point_dft.sv
// Directed bench for axis_fft_8point_dft: reset state, latency, impulse/DC/
// Nyquist/shifted-impulse bins, backpressure, sidebands, reset mid-stream.
module tb_axis_fft_8point_dft;

   typedef int arr8_t [8];
   typedef struct packed {
      logic [511:0] d;
      logic         l;
      logic         u;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         s_valid, s_ready, s_last;
   logic [63:0]  s_data;
   logic [0:0]   s_user;
   logic         m_valid, m_ready, m_last;
   logic [511:0] m_data;
   logic [63:0]  m_keep, m_strb;
   logic [0:0]   m_user;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   rx_cnt  = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   axis_fft_8point_dft dut (
      .s_axis_aclk   (clk),
      .s_axis_areset (rst),
      .s_axis_tvalid (s_valid),
      .s_axis_tready (s_ready),
      .s_axis_tdata  (s_data),
      .s_axis_tlast  (s_last),
      .s_axis_tuser  (s_user),
      .m_axis_tvalid (m_valid),
      .m_axis_tready (m_ready),
      .m_axis_tdata  (m_data),
      .m_axis_tkeep  (m_keep),
      .m_axis_tstrb  (m_strb),
      .m_axis_tlast  (m_last),
      .m_axis_tuser  (m_user)
   );

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] mk(input arr8_t re, input arr8_t im);
      logic [511:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) r[64*k +: 64] = {re[k], im[k]};
      return r;
   endfunction

   // multiply (re,im) by (-j)^p
   function automatic void rot(input int re, input int im, input int p, output int ore, output int oim);
      case (p % 4)
         0:       begin ore = re;  oim = im;  end
         1:       begin ore = im;  oim = -re; end
         2:       begin ore = -re; oim = -im; end
         default: begin ore = -im; oim = re;  end
      endcase
   endfunction

   // Reference: even bins are the DFT4 of the half-sums; odd bins the DFT4 of the
   // twiddled half-differences, where W8^1/W8^3 use Q15 c=23170 with floor shift.
   function automatic logic [511:0] ref_dft(input logic [63:0] xin);
      localparam int C = 23170;
      int x[8], a[4], d[4], br[4], bi[4];
      arr8_t ore, oim;
      logic signed [7:0] t;
      int tr, ti;
      for (int n = 0; n < 8; n++) begin
         t    = xin[8*n +: 8];
         x[n] = t;
      end
      for (int m = 0; m < 4; m++) begin
         a[m] = x[m] + x[m+4];
         d[m] = x[m] - x[m+4];
      end
      br[0] = d[0];                  bi[0] = 0;
      br[1] = (d[1] * C) >>> 15;     bi[1] = (-d[1] * C) >>> 15;
      br[2] = 0;                     bi[2] = -d[2];
      br[3] = (-d[3] * C) >>> 15;    bi[3] = (-d[3] * C) >>> 15;
      for (int r = 0; r < 4; r++) begin
         ore[2*r] = 0; oim[2*r] = 0; ore[2*r+1] = 0; oim[2*r+1] = 0;
         for (int m = 0; m < 4; m++) begin
            rot(a[m], 0, m*r, tr, ti);
            ore[2*r] += tr; oim[2*r] += ti;
            rot(br[m], bi[m], m*r, tr, ti);
            ore[2*r+1] += tr; oim[2*r+1] += ti;
         end
      end
      return mk(ore, oim);
   endfunction

   // Output monitor: scoreboard on handshakes, hold check during stalls.
   initial begin
      exp_t         e;
      logic         held_v = 1'b0;
      logic [511:0] held_d = '0;
      logic         held_l = 1'b0;
      logic [0:0]   held_u = '0;
      forever begin
         @(negedge clk); #2;
         if (held_v) begin
            chk("stall valid", m_valid, 1);
            chk("stall data", m_data, held_d);
            chk("stall side", {m_last, m_user}, {held_l, held_u});
         end
         if (m_valid && !m_ready) chk("s_tready in stall", s_ready, 0);
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("unexpected beat", 1, 0);
            else begin
               e = exp_q.pop_front();
               for (int k = 0; k < 8; k++)
                  chk($sformatf("beat%0d X%0d", rx_cnt, k), m_data[64*k +: 64], e.d[64*k +: 64]);
               chk($sformatf("beat%0d tlast", rx_cnt), m_last, e.l);
               chk($sformatf("beat%0d tuser", rx_cnt), m_user, e.u);
            end
            rx_cnt++;
         end
         held_v = m_valid && !m_ready;
         held_d = m_data;
         held_l = m_last;
         held_u = m_user;
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [63:0] x, input logic l, input logic u);
      int n = 0;
      s_valid = 1'b1; s_data = x; s_last = l; s_user = u;
      #1;
      while (!s_ready && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 50) chk("send timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0; s_user = '0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain", exp_q.size(), 0);
   endtask

   task automatic push(input logic [511:0] d, input logic l, input logic u);
      exp_q.push_back(exp_t'{d: d, l: l, u: u});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] bp_vec [6];
      logic [63:0] sb_vec [4];
      int          lat;
      int          rx_before;

      bp_vec = '{64'h7F80_0011_22EE_3355, 64'h0102_0304_0506_0708, 64'h80FF_7F01_C040_10F0,
                 64'hDEAD_BEEF_0BAD_F00D, 64'h0000_0000_7F00_0000, 64'h1234_5678_9ABC_DEF0};
      sb_vec = '{64'h0000_0000_0000_0003, 64'h0505_0505_0505_0505, 64'hF0E0_D0C0_B0A0_9080,
                 64'h0011_2233_4455_6677};

      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_user = '0; m_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #2;
      chk("reset tvalid", m_valid, 0);
      chk("reset tready", s_ready, 1);
      chk("reset tdata", m_data, 0);
      chk("reset tlast", m_last, 0);
      chk("reset tuser", m_user, 0);
      chk("tkeep/tstrb", {m_keep, m_strb}, {128{1'b1}});
      @(negedge clk);
      rst = 1'b0;

      // impulse x0=1: every bin (1,0), valid on the 4th enabled edge
      push(mk('{1,1,1,1,1,1,1,1}, '{default: 0}), 1'b0, 1'b0);
      @(negedge clk);
      s_valid = 1'b1; s_data = 64'h01;
      @(posedge clk); #1;
      s_valid = 1'b0;
      lat = 1;
      while (!m_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("impulse latency", lat, 4);
      drain();

      // DC, Nyquist and a shifted impulse back to back
      push(mk('{-1024,0,0,0,0,0,0,0}, '{default: 0}), 1'b0, 1'b0);
      push(mk('{0,0,0,0,8,0,0,0}, '{default: 0}), 1'b0, 1'b0);
      // x1=1: X[k]=W8^k with floor-rounded odd twiddles
      push(mk('{1,0,0,-1,-1,0,0,1}, '{0,-1,-1,0,0,1,1,0}), 1'b0, 1'b0);
      send(64'h8080_8080_8080_8080, 1'b0, 1'b0);
      send(64'hFF01_FF01_FF01_FF01, 1'b0, 1'b0);
      send(64'h0000_0000_0000_0100, 1'b0, 1'b0);
      drain();

      // backpressure: m_tready low for five cycles while six beats stream
      for (int i = 0; i < 6; i++) push(ref_dft(bp_vec[i]), 1'b0, 1'b0);
      fork
         begin
            m_ready = 1'b1;
            repeat (3) @(negedge clk);
            m_ready = 1'b0;
            repeat (5) @(negedge clk);
            m_ready = 1'b1;
         end
         begin
            for (int i = 0; i < 6; i++) send(bp_vec[i], 1'b0, 1'b0);
         end
      join
      drain();

      // sidebands on the third of four beats
      for (int i = 0; i < 4; i++) push(ref_dft(sb_vec[i]), i == 2, i == 2);
      for (int i = 0; i < 4; i++) send(sb_vec[i], i == 2, i == 2);
      drain();

      // reset with three beats in flight
      for (int i = 0; i < 3; i++) send(bp_vec[i], 1'b1, 1'b1);
      rst = 1'b1;
      @(negedge clk); #1;
      chk("tvalid after mid reset", m_valid, 0);
      chk("tdata after mid reset", m_data, 0);
      rst = 1'b0;
      rx_before = rx_cnt;
      repeat (12) @(negedge clk);
      chk("beats after reset", rx_cnt - rx_before, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
